// File: rtl/writeback_ctrl_if.sv
// Write-back handshake between the main control FSM (master) and the
// write-back sequencer (slave), plus the register-file control outputs.
interface writeback_ctrl_if;
  logic       wb_valid;
  logic [2:0] wb_kind;
  logic [4:0] wb_rd;
  logic       flush;
  logic       wb_ready;
  logic [3:0] wd_sel;
  logic [4:0] wr_addr;
  logic       reg_write;
  logic       done;
  logic       err_illegal;

  modport master (
    output wb_valid, wb_kind, wb_rd, flush,
    input  wb_ready, wd_sel, wr_addr, reg_write, done, err_illegal
  );

  modport slave (
    input  wb_valid, wb_kind, wb_rd, flush,
    output wb_ready, wd_sel, wr_addr, reg_write, done, err_illegal
  );
endinterface

// File: rtl/writeback_ctrl.sv
// Register-file write-back sequencer: one-shot $sp init after reset, then
// one ALU / load / extended-load / JAL write-back at a time (Moore outputs).
module writeback_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned SP_REG  = 29,
  parameter int unsigned RA_REG  = 31
) (
  input  logic             clk,
  input  logic             reset,
  writeback_ctrl_if.slave  wb
);

  localparam logic [3:0] CNT_LOAD  = 4'(MEM_LAT - 1);
  localparam logic [4:0] SP_ADDR   = 5'(SP_REG);
  localparam logic [4:0] RA_ADDR   = 5'(RA_REG);
  localparam logic [1:0] KIND_LW   = 2'd1;
  localparam logic [1:0] KIND_EXT  = 2'd2;
  localparam logic [1:0] KIND_JAL  = 2'd3;

  typedef enum logic [2:0] {
    S_BOOT,
    S_SP_INIT,
    S_IDLE,
    S_MEM_WAIT,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic [4:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fdone_q, fdone_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      kind_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fdone_q <= fdone_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fdone_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_BOOT:    state_d = S_SP_INIT;
      S_SP_INIT: state_d = S_IDLE;
      S_IDLE: begin
        // flush is deliberately not looked at here: an accept always wins
        if (wb.wb_valid) begin
          if (wb.wb_kind[2]) begin
            err_d = 1'b1;
          end else begin
            kind_d = wb.wb_kind[1:0];
            addr_d = (wb.wb_kind[1:0] == KIND_JAL) ? RA_ADDR : wb.wb_rd;
            if (wb.wb_kind[1:0] == KIND_LW || wb.wb_kind[1:0] == KIND_EXT) begin
              state_d = S_MEM_WAIT;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_MEM_WAIT: begin
        if (wb.flush) begin
          state_d = S_IDLE;
          fdone_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WRITE:   state_d = S_IDLE;
      default:   state_d = S_BOOT;
    endcase
  end

  always_comb begin
    wb.wb_ready    = (state_q == S_IDLE);
    wb.wd_sel      = '0;
    wb.wr_addr     = '0;
    wb.reg_write   = 1'b0;
    wb.done        = fdone_q;
    wb.err_illegal = err_q;
    case (state_q)
      S_SP_INIT: begin
        wb.wd_sel    = 4'b0100;
        wb.wr_addr   = SP_ADDR;
        wb.reg_write = 1'b1;
      end
      S_WRITE: begin
        // selector encoding for the four write-back kinds equals the kind code
        wb.wd_sel    = {2'b00, kind_q};
        wb.wr_addr   = addr_q;
        wb.reg_write = (addr_q != '0);
        wb.done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: the driver predicts each retire event
// (cycle, selector, address, strobes) and a negedge monitor pops and compares.
module tb_writeback_ctrl;
  localparam int MEM_LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  writeback_ctrl_if wbif ();

  writeback_ctrl #(
    .MEM_LAT (MEM_LAT),
    .SP_REG  (29),
    .RA_REG  (31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wbif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rw;
    logic [3:0] sel;
    logic [4:0] addr;
    logic       done;
    logic       err;
    int         at;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  vectors    = 0;
  int  miscompares = 0;
  int  busy_from  = 0;
  int  ready_from = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cycle check wb_ready against the model's busy window, and
  // pop one expected event whenever the DUT shows a write/done/err strobe.
  always @(negedge clk) begin
    if (!reset) begin
      check("wb_ready", wbif.wb_ready, !(cyc >= busy_from && cyc < ready_from));
      if (wbif.reg_write || wbif.done || wbif.err_illegal) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got rw=%b done=%b err=%b sel=%0d addr=%0d, expected no event (cycle %0d)",
                   wbif.reg_write, wbif.done, wbif.err_illegal, wbif.wd_sel, wbif.wr_addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_cycle", cyc, mon_e.at);
          check("reg_write", wbif.reg_write, mon_e.rw);
          check("wd_sel", wbif.wd_sel, mon_e.sel);
          check("wr_addr", wbif.wr_addr, mon_e.addr);
          check("done", wbif.done, mon_e.done);
          check("err_illegal", wbif.err_illegal, mon_e.err);
        end
      end else begin
        check("wd_sel_not_const", wbif.wd_sel == 4'b0100, 1'b0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (wbif.wb_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ready: wb_ready=%b, expected 1 within 50 cycles", wbif.wb_ready);
    end
  endtask

  // Called at posedge+1; releases reset mid-high phase and predicts SP init.
  task automatic boot();
    ev_t e;
    #2;
    reset = 1'b0;
    e = '{1'b1, 4'b0100, 5'd29, 1'b0, 1'b0, cyc + 1};
    exp_q.push_back(e);
    busy_from  = cyc;
    ready_from = cyc + 2;
    tick();
  endtask

  // flush_at: cycles after accept at which flush is pulsed for one cycle (-1 none).
  task automatic do_req(input logic [2:0] kind, input logic [4:0] rd,
                        input int flush_at, input bit flush_on_accept);
    ev_t        e;
    int         a;
    logic [4:0] addr;
    wait_ready();
    a = cyc + 1;
    wbif.wb_valid = 1'b1;
    wbif.wb_kind  = kind;
    wbif.wb_rd    = rd;
    wbif.flush    = flush_on_accept;
    addr = (kind == 3'd3) ? 5'd31 : rd;
    if (kind >= 3'd4) begin
      e = '{1'b0, 4'd0, 5'd0, 1'b0, 1'b1, a};
      busy_from  = a;
      ready_from = a;
    end else if (kind == 3'd1 || kind == 3'd2) begin
      busy_from = a;
      if (flush_at >= 0 && flush_at < MEM_LAT) begin
        e = '{1'b0, 4'd0, 5'd0, 1'b1, 1'b0, a + flush_at + 1};
        ready_from = a + flush_at + 1;
      end else begin
        e = '{addr != 5'd0, {1'b0, kind}, addr, 1'b1, 1'b0, a + MEM_LAT};
        ready_from = a + MEM_LAT + 1;
      end
    end else begin
      e = '{addr != 5'd0, {1'b0, kind}, addr, 1'b1, 1'b0, a};
      busy_from  = a;
      ready_from = a + 1;
    end
    exp_q.push_back(e);
    tick();
    wbif.wb_valid = 1'b0;
    wbif.flush    = 1'b0;
    wbif.wb_kind  = 3'($urandom);
    wbif.wb_rd    = 5'($urandom);
    if (flush_at >= 0) begin
      repeat (flush_at) tick();
      wbif.flush = 1'b1;
      tick();
      wbif.flush = 1'b0;
    end
  endtask

  task automatic random_reqs(input int n);
    int r;
    logic [2:0] kind;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 11);
      kind = (r < 10) ? 3'(r % 4) : 3'(4 + $urandom_range(0, 3));
      do_req(kind, 5'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_LAT) : -1,
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    wbif.wb_valid = 1'b0;
    wbif.wb_kind  = '0;
    wbif.wb_rd    = '0;
    wbif.flush    = 1'b0;
    repeat (3) tick();
    boot();

    do_req(3'd0, 5'd8, -1, 1'b0);
    do_req(3'd1, 5'd9, -1, 1'b0);
    do_req(3'd2, 5'd9, -1, 1'b0);
    do_req(3'd3, 5'd5, -1, 1'b0);
    do_req(3'd0, 5'd0, -1, 1'b0);
    do_req(3'd1, 5'd9, 0, 1'b0);
    do_req(3'd6, 5'd3, -1, 1'b0);
    do_req(3'd0, 5'd7, 0, 1'b1);
    do_req(3'd2, 5'd12, MEM_LAT, 1'b0);

    random_reqs(200);

    // Reset in the first MEM_WAIT cycle of a load: the load write must vanish.
    wait_ready();
    wbif.wb_valid = 1'b1;
    wbif.wb_kind  = 3'd1;
    wbif.wb_rd    = 5'd9;
    tick();
    wbif.wb_valid = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_reg_write", wbif.reg_write, 1'b0);
    check("rst_wb_ready", wbif.wb_ready, 1'b0);
    check("rst_wd_sel", wbif.wd_sel, 4'd0);
    check("rst_wr_addr", wbif.wr_addr, 5'd0);
    check("rst_done", wbif.done, 1'b0);
    check("rst_err", wbif.err_illegal, 1'b0);
    repeat (2) tick();
    boot();

    random_reqs(40);
    repeat (10) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
